// File: rtl/seq_detect_monitor_pkg.sv
// seq_detect_monitor_pkg: shared FSM encoding and default widths for the sequence monitor
package seq_detect_monitor_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_t;
  localparam int CNT_W_DEF     = 8;
  localparam int GAP_W_DEF     = 6;
  localparam int MOORE_LAT_DEF = 1;
  localparam int WARMUP_DEF    = 2;
  localparam int ERR_LIMIT_DEF = 1;
endpackage

// File: rtl/seq_detect_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;
  // count up on inc, hold at all-ones, clr wins over inc
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= '0;
    else if (clr) r_q <= '0;
    else if (inc && !(&r_q)) r_q <= r_q + 1'b1;
  assign q = r_q;
endmodule

// File: rtl/seq_detect_monitor.sv
// seq_detect_monitor: aligns Mealy to Moore latency, counts detections/mismatches, flags faults
module seq_detect_monitor
  import seq_detect_monitor_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int GAP_W     = GAP_W_DEF,
  parameter int MOORE_LAT = MOORE_LAT_DEF,
  parameter int WARMUP    = WARMUP_DEF,
  parameter int ERR_LIMIT = ERR_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mealy_in,
  input  logic             moore_in,
  input  logic             clr,
  output logic [CNT_W-1:0] det_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [GAP_W-1:0] last_gap,
  output logic             running
);
  localparam int WW = $clog2(WARMUP + 1);
  state_t               r_state, w_next;
  logic [MOORE_LAT-1:0] r_dly;
  logic [WW-1:0]        r_warm;
  logic [GAP_W-1:0]     r_lgap, w_gap;
  logic                 r_mis, r_err;
  logic                 w_al, w_run, w_d, w_trip;
  assign w_al   = r_dly[MOORE_LAT-1];
  assign w_run  = (r_state == ST_RUN);
  assign w_d    = w_al ^ moore_in;
  assign w_trip = w_run && w_d && (({1'b0, mismatch_count} + 1'b1) >= (CNT_W+1)'(ERR_LIMIT));
  sat_counter #(.W(CNT_W)) u_det (.clk(clk), .rst(rst), .clr(clr), .inc(w_run && w_al), .q(det_count));
  sat_counter #(.W(CNT_W)) u_mm  (.clk(clk), .rst(rst), .clr(clr), .inc(w_run && w_d), .q(mismatch_count));
  sat_counter #(.W(GAP_W)) u_gap (.clk(clk), .rst(rst), .clr(clr || (w_run && w_al)),
                                  .inc(w_run && !w_al), .q(w_gap));
  // Mealy delay line shifts in every state so alignment survives state changes
  always_ff @(posedge clk or posedge rst)
    if (rst) r_dly <= '0;
    else if (clr) r_dly <= '0;
    else r_dly <= MOORE_LAT'({r_dly, mealy_in});
  // state register plus warm-up counter that only advances in IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_warm  <= '0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_warm  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) r_warm <= r_warm + 1'b1;
    end
  // next state: leave IDLE after warm-up, leave RUN on reaching the error limit
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ST_IDLE && r_warm == WW'(WARMUP - 1)) ? ST_RUN :
             w_trip ? ST_FAULT : r_state;
  end
  // registered outputs: mismatch pulse, sticky error and spacing of the last two detections
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mis  <= 1'b0;
      r_err  <= 1'b0;
      r_lgap <= '0;
    end else if (clr) begin
      r_mis  <= 1'b0;
      r_err  <= 1'b0;
      r_lgap <= '0;
    end else begin
      r_mis <= w_run && w_d;
      r_err <= r_err || w_trip;
      if (w_run && w_al) r_lgap <= (&w_gap) ? w_gap : w_gap + 1'b1;
    end
  // state-decoded outputs
  always_comb begin
    running    = w_run;
    mismatch   = r_mis;
    err_sticky = r_err;
    last_gap   = r_lgap;
  end
endmodule

// File: tb/tb_seq_detect_monitor.sv
// tb_seq_detect_monitor: directed stimulus with a cycle-level reference model for two configurations
module tb_seq_detect_monitor;
  localparam int WARMUP = 2;
  localparam int LAT    = 1;
  localparam int GMAX   = 63;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mealy_in = 1'b0, moore_in = 1'b0, clr = 1'b0;
  logic [7:0] a_det, a_mm;
  logic [5:0] a_lgap, b_lgap;
  logic       a_mis, a_err, a_run, b_mis, b_err, b_run;
  logic [2:0] b_det, b_mm;
  int checks = 0, errors = 0;
  seq_detect_monitor dut_a (
    .clk(clk), .rst(rst), .mealy_in(mealy_in), .moore_in(moore_in), .clr(clr),
    .det_count(a_det), .mismatch_count(a_mm), .mismatch(a_mis), .err_sticky(a_err),
    .last_gap(a_lgap), .running(a_run));
  seq_detect_monitor #(.CNT_W(3), .ERR_LIMIT(7)) dut_b (
    .clk(clk), .rst(rst), .mealy_in(mealy_in), .moore_in(moore_in), .clr(clr),
    .det_count(b_det), .mismatch_count(b_mm), .mismatch(b_mis), .err_sticky(b_err),
    .last_gap(b_lgap), .running(b_run));
  always #5 clk = ~clk;
  // reference model: index 0 = default config, index 1 = CNT_W=3 / ERR_LIMIT=7
  int  cmax [2] = '{255, 7};
  int  elim [2] = '{1, 7};
  int  m_det [2], m_mm [2], m_gap [2], m_lgap [2];
  bit  m_mis [2], m_fault [2];
  int  m_edges;
  bit  hist [$];
  always @(posedge clk or posedge rst) begin : model
    bit al;
    if (rst || clr) begin
      m_edges = 0;
      hist = {};
      for (int k = 0; k < LAT; k++) hist.push_back(1'b0);
      for (int i = 0; i < 2; i++) begin
        m_det[i] = 0; m_mm[i] = 0; m_gap[i] = 0; m_lgap[i] = 0; m_mis[i] = 0; m_fault[i] = 0;
      end
    end else begin
      al = hist.pop_front();
      hist.push_back(mealy_in);
      for (int i = 0; i < 2; i++) begin
        m_mis[i] = 0;
        if (m_edges >= WARMUP && !m_fault[i]) begin
          if (al) begin
            m_det[i]  = (m_det[i] < cmax[i]) ? m_det[i] + 1 : cmax[i];
            m_lgap[i] = (m_gap[i] < GMAX) ? m_gap[i] + 1 : GMAX;
            m_gap[i]  = 0;
          end else m_gap[i] = (m_gap[i] < GMAX) ? m_gap[i] + 1 : GMAX;
          if (al != moore_in) begin
            m_mis[i] = 1;
            if (m_mm[i] + 1 >= elim[i]) m_fault[i] = 1;
            m_mm[i] = (m_mm[i] < cmax[i]) ? m_mm[i] + 1 : cmax[i];
          end
        end
      end
      m_edges++;
    end
  end
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic cmp();
    chk("A det_count", a_det, m_det[0]);
    chk("A mismatch_count", a_mm, m_mm[0]);
    chk("A mismatch", a_mis, m_mis[0]);
    chk("A err_sticky", a_err, m_fault[0]);
    chk("A last_gap", a_lgap, m_lgap[0]);
    chk("A running", a_run, m_edges >= WARMUP && !m_fault[0]);
    chk("B det_count", b_det, m_det[1]);
    chk("B mismatch_count", b_mm, m_mm[1]);
    chk("B mismatch", b_mis, m_mis[1]);
    chk("B err_sticky", b_err, m_fault[1]);
    chk("B last_gap", b_lgap, m_lgap[1]);
    chk("B running", b_run, m_edges >= WARMUP && !m_fault[1]);
  endtask
  // serial 10010 detector pair: Mealy is combinational on j, Moore is Mealy one cycle later
  logic [3:0] jh = '0;
  bit prev_m = 0;
  task automatic step(input bit jv, input bit kill = 0, input bit c = 0);
    logic [4:0] w;
    @(negedge clk);
    cmp();
    #1;
    w        = {jh, jv};
    mealy_in = (w == 5'b10010);
    moore_in = kill ? 1'b0 : prev_m;
    prev_m   = mealy_in;
    jh       = w[3:0];
    clr      = c;
  endtask
  task automatic raw(input bit m);
    @(negedge clk);
    cmp();
    #1;
    mealy_in = m;
    moore_in = prev_m;
    prev_m   = m;
    clr      = 1'b0;
  endtask
  task automatic stream();
    bit s [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 1};
    foreach (s[k]) step(s[k]);
    repeat (3) step(0);
  endtask
  initial begin
    // reset held for two cycles, then warm-up
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset det_count", a_det, 0);
    chk("reset err_sticky", a_err, 0);
    chk("reset running", a_run, 0);
    step(0);
    chk("warmup running edge1", a_run, 0);
    step(0);
    chk("warmup running edge2", a_run, 1);
    // clean stream: two overlapping detections three cycles apart
    stream();
    chk("stream det_count", a_det, 2);
    chk("stream last_gap", a_lgap, 3);
    chk("stream mismatch_count", a_mm, 0);
    chk("stream err_sticky", a_err, 0);
    // Moore output suppressed on the cycle after a Mealy hit
    step(1); step(0); step(0); step(1); step(0);
    step(0, 1);
    step(0);
    chk("fault mismatch pulse", a_mis, 1);
    chk("fault mismatch_count", a_mm, 1);
    chk("fault err_sticky", a_err, 1);
    chk("fault running", a_run, 0);
    chk("fault det_count", a_det, 3);
    step(0);
    chk("fault pulse one cycle", a_mis, 0);
    chk("B tolerates one mismatch", b_run, 1);
    step(1); step(0); step(0); step(1); step(0); step(0); step(0);
    chk("frozen det_count", a_det, 3);
    chk("frozen mismatch_count", a_mm, 1);
    // clr coinciding with a mismatch and a detection
    step(1); step(0); step(0); step(1); step(0);
    step(0, 1, 1);
    step(0);
    chk("clr det_count", a_det, 0);
    chk("clr mismatch_count", a_mm, 0);
    chk("clr err_sticky", a_err, 0);
    chk("clr B mismatch_count", b_mm, 0);
    chk("clr B det_count", b_det, 0);
    chk("clr running", a_run, 0);
    step(0);
    chk("rewarm running edge1", a_run, 0);
    step(0);
    chk("rewarm running edge2", a_run, 1);
    // asynchronous reset between clock edges mid-run
    step(1); step(0); step(0); step(1); step(0); step(0); step(1);
    @(negedge clk);
    cmp();
    #2;
    rst = 1'b1;
    #1;
    chk("async rst det_count", a_det, 0);
    chk("async rst last_gap", a_lgap, 0);
    chk("async rst running", a_run, 0);
    chk("async rst B det_count", b_det, 0);
    jh = '0; prev_m = 0; mealy_in = 1'b0; moore_in = 1'b0;
    step(0); step(0);
    rst = 1'b0;
    step(0); step(0);
    stream();
    chk("fresh det_count", a_det, 2);
    chk("fresh last_gap", a_lgap, 3);
    chk("fresh mismatch_count", a_mm, 0);
    // ten back-to-back aligned detections: narrow counter saturates without faulting
    repeat (10) raw(1);
    raw(0); raw(0);
    chk("sat B det_count", b_det, 7);
    chk("sat B err_sticky", b_err, 0);
    chk("sat B running", b_run, 1);
    chk("sat A det_count", a_det, 12);
    chk("sat A last_gap", a_lgap, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
